// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that ACKs a 7-bit address, delivers write bytes and serves read bytes
// from a valid/ready source, stretching SCL while no read byte is available.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         HOLD_CYC   = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       rw_o
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_h, sda_h;
  logic [3:0]  hold_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic        scl, sda, scl_rise, scl_fall, start, stop, hold_done;
  logic [7:0]  shift_in;
  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_h;
  assign scl_fall  = ~scl & scl_h;
  assign start     = scl & scl_h & ~sda & sda_h;
  assign stop      = scl & scl_h & sda & ~sda_h;
  assign hold_done = hold_cnt == 4'd1;
  assign shift_in  = {shreg, sda};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      scl_sync   <= 2'b11;
      sda_sync   <= 2'b11;
      scl_h      <= 1'b1;
      sda_h      <= 1'b1;
      hold_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      state      <= IDLE;
      scl_oe_o   <= 1'b0;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
      rw_o       <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[0], scl_i};
      sda_sync   <= {sda_sync[0], sda_i};
      scl_h      <= scl;
      sda_h      <= sda;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      // hold timer restarts on every SCL fall; a rise cancels any pending SDA change
      hold_cnt   <= scl_fall ? 4'(HOLD_CYC) : scl_rise ? 4'd0 : (hold_cnt != 4'd0) ? hold_cnt - 4'd1 : 4'd0;
      if (start) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
        scl_oe_o <= 1'b0;
        start_o  <= 1'b1;
        busy_o   <= 1'b1;
      end else if (stop) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        scl_oe_o <= 1'b0;
        stop_o   <= 1'b1;
        busy_o   <= 1'b0;
      end else
        unique case (state)
          ADDR: if (scl_rise) begin
            shreg   <= shift_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= (shift_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
              rw_o  <= (shift_in[7:1] == SLAVE_ADDR) ? sda : rw_o;
            end
          end
          // sda_oe_o doubles as the ACK phase: first hold drives, second releases
          ADDR_ACK, WR_ACK: if (hold_done) begin
            sda_oe_o <= ~sda_oe_o;
            if (sda_oe_o) state <= (state == ADDR_ACK && rw_o) ? RD_LOAD : WR_DATA;
          end
          WR_DATA: if (scl_rise) begin
            shreg   <= shift_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= shift_in;
              rx_valid_o <= 1'b1;
              state      <= WR_ACK;
            end
          end
          RD_LOAD: if (tx_valid_i) begin
            shreg      <= tx_data_i[6:0];
            sda_oe_o   <= ~tx_data_i[7];
            tx_ready_o <= 1'b1;
            state      <= RD_DATA;
          end else scl_oe_o <= 1'b1;
          RD_DATA: begin
            scl_oe_o <= 1'b0;
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
            if (hold_done) begin
              sda_oe_o <= (bit_cnt == 3'd0) ? 1'b0 : ~shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
              state    <= (bit_cnt == 3'd0) ? RD_ACK : RD_DATA;
            end
          end
          RD_ACK:
            if (scl_rise && sda) state <= IGNORE;
            else if (hold_done) state <= RD_LOAD;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master with scoreboard queues for write and read bytes.
module tb_i2c_slave_responder;
  localparam int Q = 20;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, tx_en = 1'b1;
  logic scl_oe, sda_oe, rx_valid, tx_ready, start_p, stop_p, busy, rw, tx_valid = 1'b0;
  logic [7:0] rx_data, tx_data = 8'h00;
  logic scl_bus, sda_bus;
  int checks = 0, errors = 0;
  int start_cnt = 0, stop_cnt = 0, rdy_cnt = 0, stretch_cnt = 0, sda_cnt = 0, rx_cnt = 0;
  logic [7:0] rx_q[$], tx_q[$], rd_q[$];
  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_slave_responder dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .start_o(start_p), .stop_o(stop_p), .busy_o(busy), .rw_o(rw)
  );
  always @(negedge clk) begin
    if (rst_n) begin
      start_cnt   += int'(start_p);
      stop_cnt    += int'(stop_p);
      rdy_cnt     += int'(tx_ready);
      stretch_cnt += int'(scl_oe);
      sda_cnt     += int'(sda_oe);
      if (rx_valid) begin
        logic [7:0] exp;
        rx_cnt++;
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got %h want none", rx_data);
        end else begin
          exp = rx_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_data got %h want %h", rx_data, exp);
          end
        end
      end
      if (tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
    end
    tx_valid = tx_en && tx_q.size() > 0;
    tx_data  = tx_q.size() > 0 ? tx_q[0] : 8'h00;
  end
  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_scl_high();
    int n = 0;
    while (scl_bus !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL scl_release got %b want 1", scl_bus);
    end
  endtask
  task automatic bit_x(input logic b, output logic s);
    cyc(2); sda_m = b; cyc(Q);
    scl_m = 1'b1; wait_scl_high(); cyc(Q);
    s = sda_bus; cyc(Q);
    scl_m = 1'b0;
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], s);
    bit_x(1'b1, ack);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_x(1'b1, s); d[i] = s; end
    bit_x(nack, s);
  endtask
  task automatic i2c_start();
    sda_m = 1'b0; cyc(Q); scl_m = 1'b0;
  endtask
  task automatic i2c_rep_start();
    cyc(2); sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; wait_scl_high(); cyc(Q);
    sda_m = 1'b0; cyc(Q); scl_m = 1'b0;
  endtask
  task automatic i2c_stop();
    cyc(2); sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; wait_scl_high(); cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; cyc(3);
    checks++;
    if ({scl_oe, sda_oe, rx_data, rx_valid, tx_ready, start_p, stop_p, busy, rw} !== 16'h0) begin
      errors++; $display("FAIL reset_in got %b want 0", {scl_oe, sda_oe, rx_data, rx_valid, tx_ready, start_p, stop_p, busy, rw});
    end
    rst_n = 1'b1; cyc(Q);
    checks++;
    if ({scl_oe, sda_oe, start_p, stop_p, busy} !== 5'h0) begin
      errors++; $display("FAIL reset_idle got %b want 0", {scl_oe, sda_oe, start_p, stop_p, busy});
    end
  endtask
  task automatic test_write();
    logic ack;
    int s0 = start_cnt, p0 = stop_cnt, r0 = rx_cnt;
    sda_m = 1'b0; cyc(2);
    checks++;
    if (start_p !== 1'b0) begin errors++; $display("FAIL start_early got %b want 0", start_p); end
    cyc(1);
    checks++;
    if (start_p !== 1'b1) begin errors++; $display("FAIL start_latency got %b want 1", start_p); end
    cyc(Q - 3); scl_m = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_active got %b want 1", busy); end
    write_byte(8'h44, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    rx_q.push_back(8'hA5); write_byte(8'hA5, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL wr_a5_ack got %b want 0", ack); end
    rx_q.push_back(8'h3C); write_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL wr_3c_ack got %b want 0", ack); end
    i2c_stop();
    checks++;
    if ({start_cnt - s0, stop_cnt - p0, rx_cnt - r0} !== {32'd1, 32'd1, 32'd2}) begin
      errors++; $display("FAIL wr_pulses got start %0d stop %0d rx %0d want 1 1 2", start_cnt - s0, stop_cnt - p0, rx_cnt - r0);
    end
    checks++;
    if ({busy, rw} !== 2'b00) begin errors++; $display("FAIL wr_busy_rw got %b want 00", {busy, rw}); end
  endtask
  task automatic test_bad_addr();
    logic ack;
    int r0 = rx_cnt;
    sda_cnt = 0;
    i2c_start();
    write_byte(8'h46, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL bad_addr_ack got %b want 1", ack); end
    write_byte(8'h55, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL bad_data_ack got %b want 1", ack); end
    i2c_stop();
    checks++;
    if (rx_cnt != r0 || sda_cnt != 0) begin
      errors++; $display("FAIL bad_quiet got rx %0d sda %0d want 0 0", rx_cnt - r0, sda_cnt);
    end
  endtask
  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int k0 = rdy_cnt;
    tx_q.push_back(8'h81); rd_q.push_back(8'h81);
    tx_q.push_back(8'h7E); rd_q.push_back(8'h7E);
    tx_q.push_back(8'h99);
    i2c_start();
    write_byte(8'h45, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    checks++;
    if (rw !== 1'b1) begin errors++; $display("FAIL rd_rw got %b want 1", rw); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] exp;
      read_byte(i == 1, d);
      exp = rd_q.pop_front();
      checks++;
      if (d !== exp) begin errors++; $display("FAIL rd_byte%0d got %h want %h", i, d, exp); end
    end
    i2c_stop(); cyc(Q);
    checks++;
    if (rdy_cnt - k0 != 2 || tx_q.size() != 1) begin
      errors++; $display("FAIL rd_loads got %0d left %0d want 2 1", rdy_cnt - k0, tx_q.size());
    end
    tx_q.delete();
  endtask
  task automatic test_stretch();
    logic ack;
    logic [7:0] d, exp;
    tx_en = 1'b0;
    tx_q.push_back(8'h5A); rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h45, ack);
    stretch_cnt = 0;
    fork begin cyc(220); tx_en = 1'b1; end join_none
    read_byte(1'b1, d);
    exp = rd_q.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL stretch_byte got %h want %h", d, exp); end
    checks++;
    if (stretch_cnt < 200 || stretch_cnt > 260) begin
      errors++; $display("FAIL stretch_len got %0d want 200..260", stretch_cnt);
    end
    checks++;
    if (scl_oe !== 1'b0) begin errors++; $display("FAIL stretch_release got %b want 0", scl_oe); end
    i2c_stop();
  endtask
  task automatic test_rep_start();
    logic ack;
    logic [7:0] d, exp;
    int s0 = start_cnt;
    i2c_start();
    write_byte(8'h44, ack);
    rx_q.push_back(8'hF0); write_byte(8'hF0, ack);
    checks++;
    if ({ack, rw} !== 2'b00) begin errors++; $display("FAIL rs_write got ack,rw %b want 00", {ack, rw}); end
    tx_q.push_back(8'hC3); rd_q.push_back(8'hC3);
    i2c_rep_start();
    write_byte(8'h45, ack);
    checks++;
    if ({ack, rw} !== 2'b01) begin errors++; $display("FAIL rs_read got ack,rw %b want 01", {ack, rw}); end
    read_byte(1'b1, d);
    exp = rd_q.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL rs_byte got %h want %h", d, exp); end
    i2c_stop();
    checks++;
    if (start_cnt - s0 != 2) begin errors++; $display("FAIL rs_starts got %0d want 2", start_cnt - s0); end
  endtask
  task automatic test_reset_mid();
    logic ack, s;
    logic [7:0] a = 8'h44;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(a[i], s);
    cyc(12);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_ack_drive got %b want 1", sda_oe); end
    rst_n = 1'b0; #1;
    checks++;
    if ({sda_oe, scl_oe, busy} !== 3'b000) begin errors++; $display("FAIL mid_async got %b want 000", {sda_oe, scl_oe, busy}); end
    sda_m = 1'b1; scl_m = 1'b1; cyc(5);
    rst_n = 1'b1; cyc(Q);
    i2c_start();
    write_byte(8'h44, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL mid_addr_ack got %b want 0", ack); end
    rx_q.push_back(8'h96); write_byte(8'h96, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL mid_data_ack got %b want 0", ack); end
    i2c_stop();
    checks++;
    if (rx_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got rx %0d rd %0d want 0 0", rx_q.size(), rd_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_stretch();
    test_rep_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
